// File: rtl/e_fsm_pkg.sv
// rtl/e_fsm_pkg.sv - shared encodings and request helpers for the four-floor elevator controller
package e_fsm_pkg;

    typedef enum logic [3:0] {
        S1  = 4'b0001,
        S2  = 4'b0010,
        S3  = 4'b0011,
        S4  = 4'b0100,
        S12 = 4'b1001,
        S23 = 4'b1010,
        S34 = 4'b1011,
        S21 = 4'b1101,
        S32 = 4'b1110,
        S43 = 4'b1111
    } state_t;

    typedef enum logic [2:0] {
        REQ_NONE = 3'b000,
        REQ_1U   = 3'b001,
        REQ_2U   = 3'b010,
        REQ_3U   = 3'b011,
        REQ_4D   = 3'b100,
        REQ_BAD  = 3'b101,
        REQ_2D   = 3'b110,
        REQ_3D   = 3'b111
    } req_t;

    typedef enum logic [1:0] {
        DIR_UP   = 2'b00,
        DIR_DOWN = 2'b01,
        DIR_STAY = 2'b10
    } dir_t;

    localparam int NUM_REQ = 6;

    function automatic logic [2:0] req_floor(input logic [2:0] code);
        case (code)
            REQ_1U:         return 3'd1;
            REQ_2U, REQ_2D: return 3'd2;
            REQ_3U, REQ_3D: return 3'd3;
            REQ_4D:         return 3'd4;
            default:        return 3'd0;
        endcase
    endfunction

    // Buffer bit order doubles as service priority: 1U, 2U, 3U, 2D, 3D, 4D.
    function automatic logic [NUM_REQ-1:0] req_onehot(input logic [2:0] code);
        case (code)
            REQ_1U:  return 6'b000001;
            REQ_2U:  return 6'b000010;
            REQ_3U:  return 6'b000100;
            REQ_2D:  return 6'b001000;
            REQ_3D:  return 6'b010000;
            REQ_4D:  return 6'b100000;
            default: return 6'b000000;
        endcase
    endfunction

    function automatic logic [2:0] bit_code(input int idx);
        case (idx)
            0:       return REQ_1U;
            1:       return REQ_2U;
            2:       return REQ_3U;
            3:       return REQ_2D;
            4:       return REQ_3D;
            5:       return REQ_4D;
            default: return REQ_NONE;
        endcase
    endfunction

endpackage

// File: rtl/e_fsm_lift.sv
// rtl/e_fsm_lift.sv - lift FSM serving one target at a time with registered motor command
module e_fsm_lift
    import e_fsm_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       q_empty,
    input  logic [2:0] data,
    output logic       done,
    output logic [2:0] target,
    output logic [1:0] dout
);

    state_t     crt_state;
    state_t     nxt_state;
    logic [2:0] in;
    logic [2:0] tgt_floor;
    logic [2:0] cur_floor;

    assign tgt_floor = req_floor(in);
    assign cur_floor = crt_state[2:0];
    assign target    = in;

    always_comb begin
        nxt_state = crt_state;
        done      = 1'b0;
        case (crt_state)
            S12: nxt_state = S2;
            S23: nxt_state = S3;
            S34: nxt_state = S4;
            S21: nxt_state = S1;
            S32: nxt_state = S2;
            S43: nxt_state = S3;
            S1, S2, S3, S4: begin
                if (in != REQ_NONE) begin
                    if (tgt_floor == cur_floor) begin
                        done = 1'b1;
                    end else if (tgt_floor > cur_floor) begin
                        case (crt_state)
                            S1:      nxt_state = S12;
                            S2:      nxt_state = S23;
                            default: nxt_state = S34;
                        endcase
                    end else begin
                        case (crt_state)
                            S4:      nxt_state = S43;
                            S3:      nxt_state = S32;
                            default: nxt_state = S21;
                        endcase
                    end
                end
            end
            default: nxt_state = S1;
        endcase
    end

    // dout is derived from nxt_state so the registered command always matches crt_state.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            crt_state <= S1;
            in        <= REQ_NONE;
            dout      <= DIR_STAY;
        end else begin
            crt_state <= nxt_state;
            if (!nxt_state[3]) begin
                dout <= DIR_STAY;
            end else if (nxt_state[2]) begin
                dout <= DIR_DOWN;
            end else begin
                dout <= DIR_UP;
            end
            if (done) begin
                in <= REQ_NONE;
            end else if (in == REQ_NONE && !crt_state[3] && !q_empty) begin
                in <= data;
            end
        end
    end

endmodule

// File: rtl/e_fsm_req_buf.sv
// rtl/e_fsm_req_buf.sv - pending hall-call bitmap with lowest-index-first request selection
module e_fsm_req_buf
    import e_fsm_pkg::*;
(
    input  logic               clk,
    input  logic               rst_n,
    input  logic [2:0]         din,
    input  logic               done,
    input  logic [2:0]         target,
    output logic [NUM_REQ-1:0] buffer,
    output logic               q_empty,
    output logic [2:0]         data
);

    logic [NUM_REQ-1:0] clr_mask;

    assign clr_mask = done ? req_onehot(target) : '0;

    // Set is OR-ed after the clear so a press on the done edge keeps the bit pending.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            buffer <= '0;
        end else begin
            buffer <= (buffer & ~clr_mask) | req_onehot(din);
        end
    end

    always_comb begin
        data = REQ_NONE;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            if (buffer[i]) begin
                data = bit_code(i);
            end
        end
    end

    assign q_empty = (buffer == '0);

endmodule

// File: rtl/e_fsm.sv
// rtl/e_fsm.sv - four-floor elevator controller top: request buffer feeding the lift FSM
module e_fsm
    import e_fsm_pkg::*;
(
    input  logic       clk_Buf,
    input  logic       clk_FSM,
    input  logic       rst_n,
    input  logic [2:0] din,
    output logic [1:0] dout
);

    logic               qEmpty_Buf_to_LiftFSM;
    logic               done_LiftFSM_to_Buf;
    logic [2:0]         data_Buf_to_LiftFSM;
    logic [2:0]         target_code;
    logic [NUM_REQ-1:0] pending;

    e_fsm_req_buf InputBuf (
        .clk     (clk_Buf),
        .rst_n   (rst_n),
        .din     (din),
        .done    (done_LiftFSM_to_Buf),
        .target  (target_code),
        .buffer  (pending),
        .q_empty (qEmpty_Buf_to_LiftFSM),
        .data    (data_Buf_to_LiftFSM)
    );

    e_fsm_lift FSM (
        .clk     (clk_FSM),
        .rst_n   (rst_n),
        .q_empty (qEmpty_Buf_to_LiftFSM),
        .data    (data_Buf_to_LiftFSM),
        .done    (done_LiftFSM_to_Buf),
        .target  (target_code),
        .dout    (dout)
    );

endmodule

// File: tb/tb_e_fsm.sv
// tb/tb_e_fsm.sv - scoreboard bench for e_fsm against an integer-floor elevator model
module tb_e_fsm;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [2:0] din = 3'b000;
    logic [1:0] dout;

    always #5 clk = ~clk;

    e_fsm dut (
        .clk_Buf (clk),
        .clk_FSM (clk),
        .rst_n   (rst_n),
        .din     (din),
        .dout    (dout)
    );

    typedef struct {
        logic [3:0] st;
        logic [1:0] dout;
        logic       done;
        logic [5:0] pend;
        logic [2:0] tgt;
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   errors = 0;

    // Model: car position as a floor number, a travel flag and a direction sign.
    int         m_pos = 1;
    int         m_dir = 0;
    bit         m_moving = 1'b0;
    logic [2:0] m_tgt = 3'd0;
    logic [5:0] m_pend = 6'd0;

    function automatic int bit_of(input logic [2:0] c);
        case (c)
            3'b001:  return 0;
            3'b010:  return 1;
            3'b011:  return 2;
            3'b110:  return 3;
            3'b111:  return 4;
            3'b100:  return 5;
            default: return -1;
        endcase
    endfunction

    function automatic logic [2:0] code_of(input int b);
        logic [2:0] tbl [6];
        tbl = '{3'b001, 3'b010, 3'b011, 3'b110, 3'b111, 3'b100};
        return tbl[b];
    endfunction

    function automatic int floor_of(input logic [2:0] c);
        case (c)
            3'b001:         return 1;
            3'b010, 3'b110: return 2;
            3'b011, 3'b111: return 3;
            3'b100:         return 4;
            default:        return 0;
        endcase
    endfunction

    function automatic bit model_done();
        return !m_moving && m_tgt != 3'd0 && floor_of(m_tgt) == m_pos;
    endfunction

    task automatic model_step(input logic [2:0] d, input bit r);
        bit         dn;
        logic [5:0] old_pend;
        if (r) begin
            m_pos = 1; m_dir = 0; m_moving = 1'b0; m_tgt = 3'd0; m_pend = 6'd0;
            return;
        end
        dn = model_done();
        old_pend = m_pend;
        if (dn) m_pend[bit_of(m_tgt)] = 1'b0;
        if (bit_of(d) >= 0) m_pend[bit_of(d)] = 1'b1;
        if (m_moving) begin
            m_pos = m_pos + m_dir;
            m_moving = 1'b0;
        end else if (m_tgt == 3'd0) begin
            for (int i = 5; i >= 0; i--) if (old_pend[i]) m_tgt = code_of(i);
        end else if (dn) begin
            m_tgt = 3'd0;
        end else begin
            m_moving = 1'b1;
            m_dir = (floor_of(m_tgt) > m_pos) ? 1 : -1;
        end
    endtask

    function automatic exp_t expect_now();
        exp_t e;
        if (m_moving) e.st = (m_dir > 0) ? 4'(8 + m_pos) : 4'(12 + m_pos - 1);
        else          e.st = 4'(m_pos);
        e.dout = m_moving ? ((m_dir > 0) ? 2'b00 : 2'b01) : 2'b10;
        e.done = model_done();
        e.pend = m_pend;
        e.tgt  = m_tgt;
        return e;
    endfunction

    task automatic tick(input logic [2:0] d, input bit r);
        din = d;
        rst_n = !r;
        model_step(d, r);
        @(posedge clk);
        q.push_back(expect_now());
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick(3'b000, 1'b0);
    endtask

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            if (q.size() > 0) begin
                e = q.pop_front();
                chk("state",  8'(dut.FSM.crt_state),         8'(e.st));
                chk("dout",   8'(dout),                      8'(e.dout));
                chk("done",   8'(dut.done_LiftFSM_to_Buf),   8'(e.done));
                chk("buffer", 8'(dut.InputBuf.buffer),       8'(e.pend));
                chk("target", 8'(dut.FSM.in),                8'(e.tgt));
                chk("qempty", 8'(dut.qEmpty_Buf_to_LiftFSM), 8'(e.pend == 6'd0));
            end
        end
    end

    initial begin : stim
        logic [2:0] burst [6];
        int         guard;
        burst = '{3'b100, 3'b110, 3'b011, 3'b111, 3'b001, 3'b010};

        tick(3'b000, 1'b1);
        tick(3'b000, 1'b1);

        tick(3'b001, 1'b0); tick(3'b001, 1'b0); idle(6);
        tick(3'b011, 1'b0); idle(10);
        tick(3'b110, 1'b0); idle(8);
        tick(3'b100, 1'b0); idle(10);

        foreach (burst[i]) begin
            tick(burst[i], 1'b0);
            if ($urandom_range(0, 1) == 1) tick(burst[i], 1'b0);
        end
        idle(70);

        tick(3'b001, 1'b0); idle(2); tick(3'b000, 1'b1);
        tick(3'b100, 1'b0); idle(3); tick(3'b100, 1'b0); tick(3'b100, 1'b0);
        tick(3'b101, 1'b0); idle(20);

        for (int i = 0; i < 1500; i++) begin
            if ($urandom_range(0, 3) == 0) tick(3'($urandom_range(0, 7)), $urandom_range(0, 399) == 0);
            else                           tick(3'b000, $urandom_range(0, 399) == 0);
        end

        guard = 0;
        while ((m_pend != 6'd0 || m_tgt != 3'd0 || m_moving) && guard < 300) begin
            tick(3'b000, 1'b0);
            guard++;
        end
        checks++;
        if (guard >= 300) begin
            errors++;
            $display("FAIL drain actual=busy expected=idle");
        end

        @(negedge clk);
        #1;
        checks++;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_left actual=%0d expected=0", q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/e_fsm.md
# e_fsm

Four-floor elevator controller. It has two stages:
- A request buffer that latches hall-call buttons into a pending bitmap.
- A lift FSM that serves one request at a time and drives the car motor direction.

The block sits between the hall-call button encoder (`din`) and the motor driver (`dout`).

## Interface
Parameters: none. Encodings are fixed constants in the package.

- `clk_Buf`  in  1  buffer clock; tied to the single system clock.
- `clk_FSM`  in  1  FSM clock; same net as `clk_Buf`. The design is one clock domain.
- `rst_n`  in  1  synchronous, active-low reset.
- `din`  in  3  request code, sampled every rising edge:
  - `000` none, `001` 1U, `010` 2U, `011` 3U, `110` 2D, `111` 3D, `100` 4D.
  - `101` is ignored.
- `dout`  out  2  motor command: `00` UP, `01` DOWN, `10` STAY. `11` is never driven.

## Operation
- **Request buffer:** `buffer[5:0]`, one bit per request.
  - Bit 0 = 1U, 1 = 2U, 2 = 3U, 3 = 2D, 4 = 3D, 5 = 4D.
  - A valid `din` sets its bit. A held or repeated press of a pending request has no further effect.
- **Buffer outputs to the FSM:**
  - `qEmpty_Buf_to_LiftFSM` = (`buffer` == 0).
  - `data_Buf_to_LiftFSM` = code of the lowest set bit, or `000` when empty.
- **Done handling:**
  - `done_LiftFSM_to_Buf` clears the bit of the FSM's current target at that edge.
  - If the same request is pressed at that edge, set wins and the bit stays pending.
- **Request floor:** 1U→1; 2U, 2D→2; 3U, 3D→3; 4D→4.
- **FSM state:** `crt_state[3:0]`.
  - Bit 3: 0 = idle at a floor, 1 = moving.
  - Bit 2: direction while moving, 0 = up, 1 = down.
- **States:**
  - Idle: `S1`=0001, `S2`=0010, `S3`=0011, `S4`=0100.
  - Moving up: `S12`=1001, `S23`=1010, `S34`=1011.
  - Moving down: `S21`=1101, `S32`=1110, `S43`=1111.
- **Target register:** `in[2:0]`, where `000` means no target.
  - Loads `data_Buf_to_LiftFSM` when `in`==0, the state is idle and `qEmpty`=0.
- **Idle floor n with target floor t:**
  - t == n: `done`=1 (combinational) and `in`←0; the state stays.
  - t > n: next state is `S n(n+1)`.
  - t < n: next state is `S n(n-1)`.
- **Moving states:** a moving state always goes to its destination floor state on the next edge.
- **Output (Moore):**
  - UP in `S12`, `S23`, `S34`.
  - DOWN in `S21`, `S32`, `S43`.
  - STAY in `S1`–`S4`.
- Only the target request is cleared on arrival. Passing a floor does not clear other pending requests.

## Timing
- **Reset** (rst_n=0 at an edge):
  - `crt_state`=`S1`, `in`=0, `buffer`=0.
  - Outputs: `dout`=STAY, `done`=0, `qEmpty`=1.
  - Reset mid-travel returns to `S1` immediately and drops all requests.
- **Latency,** with the press sampled at edge E0:
  - E0: buffer bit set.
  - E1: FSM latches the target.
  - Same-floor target: `done` is high during E1–E2 and the bit clears at E2.
  - Otherwise one floor per two cycles: E2 moving, E3 next floor, and so on.
  - `done` is asserted in the cycle after arrival.
- The FSM accepts the next request one edge after `done`, when `in`==0 and the bit is already cleared.
- Service order among pending requests is fixed: lowest bit index first.

## Structure
- **Package:**
  - State, request and output encodings.
  - A function mapping request code to floor.
- **Sub-module `e_fsm_req_buf`,** instance name `InputBuf`:
  - Holds `buffer`.
  - Produces `qEmpty_Buf_to_LiftFSM` and `data_Buf_to_LiftFSM`.
- **Lift FSM,** instance name `FSM`:
  - Exposes `crt_state`, `nxt_state` and `in`.
- Top-level nets keep the names `qEmpty_Buf_to_LiftFSM`, `done_LiftFSM_to_Buf` and `data_Buf_to_LiftFSM` for hierarchical probing.

## Test plan
- **Reset:** hold rst_n=0 for 2 cycles → `S1`, `dout`=STAY, `buffer`=0, `qEmpty`=1.
- **Same floor:** at `S1`, press 1U (`001`) for 2 cycles → `buffer`=000001, `done` pulses once, the bit clears, and `dout` stays STAY.
- **Up travel:** at `S1`, press 3U → states `S12`, `S2`, `S23`, `S3`; `dout` is UP, STAY, UP, STAY; `done` at `S3`; `buffer` returns to 0.
- **Down travel:** at `S3`, press 2D → `S32` (DOWN), then `S2`, then `done`. Next press 4D → `S23`, `S3`, `S34`, `S4`.
- **Burst:** press 4D, 2D, 3U, 3D, 1U, 2U back-to-back, 1–2 cycles each → `buffer`=111111. Requests are served in bit order 1U, 2U, 3U, 2D, 3D, 4D. The buffer ends at 0 and the car at `S4`.
- **Reset and duplicates:** assert reset while in `S23` → `S1` next edge, `buffer` cleared. Repress a pending 4D → no duplicate service.
